// File: rtl/matrix_3x3_window_pkg.sv
// Shared constants and helpers for the 3x3 window generator and its line delays.
package matrix_3x3_window_pkg;

    localparam int ROW_TOP = 0;
    localparam int ROW_MID = 1;
    localparam int ROW_CUR = 2;

    localparam int COL_OLD = 0;
    localparam int COL_MID = 1;
    localparam int COL_NEW = 2;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/matrix_3x3_window_if.sv
// Pixel-stream input and 3x3 window output bundle of matrix_3x3_window.
interface matrix_3x3_window_if #(
    parameter int INPUT_WIDTH = 8
);
    logic                   in_vsync;
    logic                   in_href;
    logic                   in_clken;
    logic [INPUT_WIDTH-1:0] in_data;

    logic                   post_vsync;
    logic                   post_href;
    logic                   matrix_clken;
    logic                   matrix_valid;
    logic [INPUT_WIDTH-1:0] matrix_p11;
    logic [INPUT_WIDTH-1:0] matrix_p12;
    logic [INPUT_WIDTH-1:0] matrix_p13;
    logic [INPUT_WIDTH-1:0] matrix_p21;
    logic [INPUT_WIDTH-1:0] matrix_p22;
    logic [INPUT_WIDTH-1:0] matrix_p23;
    logic [INPUT_WIDTH-1:0] matrix_p31;
    logic [INPUT_WIDTH-1:0] matrix_p32;
    logic [INPUT_WIDTH-1:0] matrix_p33;

    modport master (
        output in_vsync, in_href, in_clken, in_data,
        input  post_vsync, post_href, matrix_clken, matrix_valid,
        input  matrix_p11, matrix_p12, matrix_p13,
        input  matrix_p21, matrix_p22, matrix_p23,
        input  matrix_p31, matrix_p32, matrix_p33
    );

    modport slave (
        input  in_vsync, in_href, in_clken, in_data,
        output post_vsync, post_href, matrix_clken, matrix_valid,
        output matrix_p11, matrix_p12, matrix_p13,
        output matrix_p21, matrix_p22, matrix_p23,
        output matrix_p31, matrix_p32, matrix_p33
    );

endinterface

// File: rtl/matrix_3x3_window_line_delay_ram.sv
// Circular-buffer line delay: dout is the sample written DEPTH enables ago.
module matrix_3x3_window_line_delay_ram
    import matrix_3x3_window_pkg::*;
#(
    parameter int DEPTH = 640,
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);
    localparam int PTR_W = cnt_width(DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [PTR_W-1:0] PTR_ZERO = {PTR_W{1'b0}};
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] ptr_r;

    // Read-before-write on the same slot gives exactly DEPTH enables of delay.
    assign dout = mem_r[ptr_r];

    // Pointer advances and wraps on every enable.
    always_ff @(posedge clock) begin
        if (reset) begin
            ptr_r <= PTR_ZERO;
        end else if (en) begin
            ptr_r <= (ptr_r == PTR_LAST) ? PTR_ZERO : ptr_r + PTR_ONE;
        end
    end

    // Storage is intentionally never cleared; the window logic masks stale lines.
    always_ff @(posedge clock) begin
        if (en) begin
            mem_r[ptr_r] <= din;
        end
    end

endmodule

// File: rtl/matrix_3x3_window.sv
// 3x3 neighbourhood generator over a raster stream with two line delays and border handling.
// Define BORDER_REPLICATE_EN to replicate edge pixels instead of zero-filling outside the frame.
module matrix_3x3_window
    import matrix_3x3_window_pkg::*;
#(
    parameter int IMG_WIDTH   = 640,
    parameter int IMG_HEIGHT  = 480,
    parameter int INPUT_WIDTH = 8
) (
    input  logic               clock,
    input  logic               reset,
    matrix_3x3_window_if.slave bus
);
    localparam int COL_W = cnt_width(IMG_WIDTH);
    localparam int ROW_W = cnt_width(IMG_HEIGHT);

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
    localparam logic [COL_W-1:0] COL_ZERO = {COL_W{1'b0}};
    localparam logic [COL_W-1:0] COL_ONE  = COL_W'(1);
    localparam logic [COL_W-1:0] COL_TWO  = COL_W'(2);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);
    localparam logic [ROW_W-1:0] ROW_ZERO = {ROW_W{1'b0}};
    localparam logic [ROW_W-1:0] ROW_ONE  = ROW_W'(1);
    localparam logic [ROW_W-1:0] ROW_TWO  = ROW_W'(2);
    localparam logic [INPUT_WIDTH-1:0] PIX_ZERO = {INPUT_WIDTH{1'b0}};

    logic                   vsync_d_r;
    logic                   href_d_r;
    logic                   clken_r;
    logic                   valid_r;
    logic [COL_W-1:0]       col_r;
    logic [ROW_W-1:0]       row_r;
    logic [INPUT_WIDTH-1:0] win_r [3][3];

    logic                   vsync_rise_s;
    logic                   accept_s;
    logic                   short_line_s;
    logic                   line_wrap_s;
    logic [ROW_W-1:0]       row_next_s;
    logic [INPUT_WIDTH-1:0] mid_raw_s;
    logic [INPUT_WIDTH-1:0] top_raw_s;
    logic [INPUT_WIDTH-1:0] new_col_s [3];
    logic [INPUT_WIDTH-1:0] fill_s [3];

    // Frame/line event decode; a frame start swallows any coincident pixel.
    always_comb begin
        vsync_rise_s = bus.in_vsync & ~vsync_d_r;
        accept_s     = bus.in_clken & bus.in_href & ~vsync_rise_s;
        short_line_s = href_d_r & ~bus.in_href & (col_r != COL_ZERO);
        line_wrap_s  = accept_s & (col_r == COL_LAST);
        if (row_r == ROW_LAST) begin
            row_next_s = row_r;
        end else begin
            row_next_s = row_r + ROW_ONE;
        end
    end

    // Incoming window column and the value used for columns left of the frame.
    always_comb begin
        new_col_s[ROW_CUR] = bus.in_data;
`ifdef BORDER_REPLICATE_EN
        if (row_r == ROW_ZERO) begin
            new_col_s[ROW_TOP] = bus.in_data;
            new_col_s[ROW_MID] = bus.in_data;
        end else if (row_r == ROW_ONE) begin
            new_col_s[ROW_TOP] = mid_raw_s;
            new_col_s[ROW_MID] = mid_raw_s;
        end else begin
            new_col_s[ROW_TOP] = top_raw_s;
            new_col_s[ROW_MID] = mid_raw_s;
        end
        for (int i = 0; i < 3; i++) begin
            fill_s[i] = new_col_s[i];
        end
`else
        if (row_r < ROW_TWO) begin
            new_col_s[ROW_TOP] = PIX_ZERO;
        end else begin
            new_col_s[ROW_TOP] = top_raw_s;
        end
        if (row_r < ROW_ONE) begin
            new_col_s[ROW_MID] = PIX_ZERO;
        end else begin
            new_col_s[ROW_MID] = mid_raw_s;
        end
        for (int i = 0; i < 3; i++) begin
            fill_s[i] = PIX_ZERO;
        end
`endif
    end

    // Input sync delays; they double as the aligned post_vsync/post_href outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            vsync_d_r <= 1'b0;
            href_d_r  <= 1'b0;
        end else begin
            vsync_d_r <= bus.in_vsync;
            href_d_r  <= bus.in_href;
        end
    end

    // Raster position; rows saturate so oversized frames keep flowing.
    always_ff @(posedge clock) begin
        if (reset || vsync_rise_s) begin
            col_r <= COL_ZERO;
            row_r <= ROW_ZERO;
        end else if (line_wrap_s || short_line_s) begin
            col_r <= COL_ZERO;
            row_r <= row_next_s;
        end else if (accept_s) begin
            col_r <= col_r + COL_ONE;
        end
    end

    // Window shift registers, update strobe and interior flag.
    always_ff @(posedge clock) begin
        if (reset || vsync_rise_s) begin
            clken_r <= 1'b0;
            valid_r <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                for (int j = 0; j < 3; j++) begin
                    win_r[i][j] <= PIX_ZERO;
                end
            end
        end else begin
            clken_r <= accept_s;
            if (accept_s) begin
                valid_r <= (row_r >= ROW_TWO) && (col_r >= COL_TWO);
                for (int i = 0; i < 3; i++) begin
                    win_r[i][COL_NEW] <= new_col_s[i];
                    if (col_r == COL_ZERO) begin
                        win_r[i][COL_OLD] <= fill_s[i];
                        win_r[i][COL_MID] <= fill_s[i];
                    end else if (col_r == COL_ONE) begin
                        win_r[i][COL_OLD] <= fill_s[i];
                        win_r[i][COL_MID] <= win_r[i][COL_NEW];
                    end else begin
                        win_r[i][COL_OLD] <= win_r[i][COL_MID];
                        win_r[i][COL_MID] <= win_r[i][COL_NEW];
                    end
                end
            end
        end
    end

    matrix_3x3_window_line_delay_ram #(
        .DEPTH (IMG_WIDTH),
        .WIDTH (INPUT_WIDTH)
    ) u_line_delay_1 (
        .clock (clock),
        .reset (reset),
        .en    (accept_s),
        .din   (bus.in_data),
        .dout  (mid_raw_s)
    );

    matrix_3x3_window_line_delay_ram #(
        .DEPTH (IMG_WIDTH),
        .WIDTH (INPUT_WIDTH)
    ) u_line_delay_2 (
        .clock (clock),
        .reset (reset),
        .en    (accept_s),
        .din   (mid_raw_s),
        .dout  (top_raw_s)
    );

    assign bus.post_vsync   = vsync_d_r;
    assign bus.post_href    = href_d_r;
    assign bus.matrix_clken = clken_r;
    assign bus.matrix_valid = valid_r;
    assign bus.matrix_p11   = win_r[ROW_TOP][COL_OLD];
    assign bus.matrix_p12   = win_r[ROW_TOP][COL_MID];
    assign bus.matrix_p13   = win_r[ROW_TOP][COL_NEW];
    assign bus.matrix_p21   = win_r[ROW_MID][COL_OLD];
    assign bus.matrix_p22   = win_r[ROW_MID][COL_MID];
    assign bus.matrix_p23   = win_r[ROW_MID][COL_NEW];
    assign bus.matrix_p31   = win_r[ROW_CUR][COL_OLD];
    assign bus.matrix_p32   = win_r[ROW_CUR][COL_MID];
    assign bus.matrix_p33   = win_r[ROW_CUR][COL_NEW];

endmodule

// File: doc/matrix_3x3_window.md
Name: matrix_3x3_window

Overview:
- Reader side of the line-delay buffering used by the image operators.
- Consumes a raster pixel stream and keeps two line delays internally.
- Emits a registered 3x3 neighbourhood per accepted pixel for downstream Sobel/median/erode stages.
- Tracks row/column position so that pixels outside the frame are masked rather than taken from stale line-RAM contents.

Parameters:
- IMG_WIDTH, 640, active pixels per line; line-delay depth.
- IMG_HEIGHT, 480, active lines per frame; row counter saturates at IMG_HEIGHT-1.
- INPUT_WIDTH, 8, pixel width in bits.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- in_vsync  in  1  frame sync; rising edge starts a frame.
- in_href  in  1  line-active qualifier.
- in_clken  in  1  pixel strobe; a pixel is accepted when in_clken & in_href.
- in_data  in  INPUT_WIDTH  pixel value.
- post_vsync  out  1  in_vsync delayed 1 clock.
- post_href  out  1  in_href delayed 1 clock.
- matrix_clken  out  1  one-clock pulse: window updated.
- matrix_valid  out  1  window lies fully inside the frame.
- matrix_p11..p13, p21..p23, p31..p33  out  INPUT_WIDTH each.
  - Row 1 is oldest line, row 3 is current line.
  - Column 1 is oldest pixel, column 3 is newest.

Behaviour:
- Reset:
  - All outputs 0; col/row counters 0.
  - Line-delay write pointers 0. Line-RAM contents are not cleared; masking handles stale data.
- Accept = in_clken & in_href & !vsync_rise, where vsync_rise = in_vsync & !in_vsync_d.
- vsync_rise:
  - col=0, row=0, all window registers cleared.
  - Takes priority over a simultaneous accept, and that pixel is dropped.
- On accept at position (r,c):
  - Line delay 1 outputs (r-1,c); line delay 2 outputs (r-2,c).
  - Each window row shifts left: p*1<=p*2, p*2<=p*3.
  - New column: p13<=top, p23<=mid, p33<=in_data.
- Latency: matrix_clken asserts exactly 1 clock after the accept, with p33 = pixel accepted that cycle. post_vsync/post_href are aligned to it.
- Masking, default build:
  - top forced to 0 when r<2; mid forced to 0 when r<1.
  - When c==0, p*1 and p*2 load 0 instead of shifting, so columns left of the frame read 0.
  - When c==1, p*1 loads 0.
- matrix_valid = registered (r>=2 && c>=2), updated on the same clock as matrix_clken. It holds its value between pulses.
- Counters:
  - c==IMG_WIDTH-1 on accept: c<=0, r<=min(r+1, IMG_HEIGHT-1).
  - Short line (falling edge of in_href with c!=0): c<=0, r increments the same way.
  - Rows beyond IMG_HEIGHT keep processing at r=IMG_HEIGHT-1.
- Line delays advance only on accept. Stalls (in_clken low with in_href high) hold all state; matrix_clken stays low.
- Reset mid-line: same as reset. The next accepted pixel is treated as (0,0) until vsync_rise.

Optional Feature:
- BORDER_REPLICATE_EN.
- Defined:
  - Missing rows replicate the nearest existing row: r==0 gives top=mid=in_data; r==1 gives top=mid.
  - Missing columns replicate column 3 of the same window row.
  - matrix_valid still reflects true interior (r>=2 && c>=2).
- Undefined: zero fill as above.

Decomposition:
- Shared package holds:
  - window index constants (ROW_TOP/MID/CUR, COL_OLD/MID/NEW);
  - the counter-width function clog2(IMG_WIDTH), clog2(IMG_HEIGHT).
- One sub-module: line_delay_ram.
  - Circular buffer of depth IMG_WIDTH with synchronous-reset pointer, written and read on the same enable.
  - Instantiated twice in series.

Test Plan:
All tests use IMG_WIDTH=4, IMG_HEIGHT=4 and in_data = 16*r + c.
1. Full frame, in_clken continuous. The accept at (2,2) gives p11..p33 = 0x00,0x01,0x02 / 0x10,0x11,0x12 / 0x20,0x21,0x22, with matrix_valid=1 one clock later.
2. Top border, default build. The accept at (0,3) gives top/mid rows all 0, p31..p33 = 0x01,0x02,0x03, and matrix_valid=0.
3. Same accept at (0,3) with BORDER_REPLICATE_EN. All three rows read 0x01,0x02,0x03.
4. Stall: hold in_clken low for 5 clocks mid-line. No matrix_clken pulses and the window is unchanged; the next accept resumes at the correct c.
5. vsync_rise coincident with in_clken&in_href. The pixel is dropped and counters reset; the next accept is (0,0) with window = 0 except p33.
6. Reset asserted at (3,1), then new frame data. Stale line-RAM data never appears: top/mid rows are 0 for rows 0/1 of the new frame.
